// File: rtl/soc_gpio.sv
// Memory-mapped GPIO: synchronised, debounced switch inputs with rising-edge latches,
// an LED output register, per-bit interrupt enables and a registered level interrupt.
module soc_gpio #(
    parameter int DATA_W    = 16,
    parameter int N_SW      = 16,
    parameter int N_LED     = 16,
    parameter int DB_CYCLES = 4,
    parameter logic [N_LED-1:0] LED_RST = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              we,
    input  logic              re,
    output logic [DATA_W-1:0] rdata,
    input  logic [N_SW-1:0]   switches,
    output logic [N_LED-1:0]  leds,
    output logic              irq
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {
        REG_LED    = 2'd0,
        REG_SW     = 2'd1,
        REG_EDGE   = 2'd2,
        REG_IRQ_EN = 2'd3
    } reg_sel_t;

    logic [N_SW-1:0]   sync1;
    logic [N_SW-1:0]   s;
    logic [N_SW-1:0]   sw_db;
    logic [N_SW-1:0]   sw_db_next;
    logic [N_SW-1:0]   edge_lat;
    logic [N_SW-1:0]   edge_next;
    logic [N_SW-1:0]   edge_clr;
    logic [N_SW-1:0]   irq_en;
    logic [N_LED-1:0]  led_reg;
    logic [DATA_W-1:0] rd_val;
    logic [CW-1:0]     cnt      [N_SW];
    logic [CW-1:0]     cnt_next [N_SW];

    // NOTE: every combinational output gets a default before any branch, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        sw_db_next = sw_db;
        for (int i = 0; i < N_SW; i++) begin
            cnt_next[i] = '0;
            if (s[i] != sw_db[i]) begin
                // Accept the new level on the DB_CYCLES-th consecutive differing sample.
                if (cnt[i] == CW'(DB_CYCLES - 1)) sw_db_next[i] = s[i];
                else                              cnt_next[i]   = cnt[i] + CW'(1);
            end
        end

        edge_clr = '0;
        if (we && reg_sel_t'(addr) == REG_EDGE) edge_clr = wdata[N_SW-1:0];
        // A rising edge landing on the same cycle as its W1C clear survives.
        edge_next = (edge_lat & ~edge_clr) | (sw_db_next & ~sw_db);

        rd_val = '0;
        case (reg_sel_t'(addr))
            REG_LED:    rd_val[N_LED-1:0] = led_reg;
            REG_SW:     rd_val[N_SW-1:0]  = sw_db;
            REG_EDGE:   rd_val[N_SW-1:0]  = edge_lat;
            REG_IRQ_EN: rd_val[N_SW-1:0]  = irq_en;
            default:    rd_val = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= '0;
            s        <= '0;
            sw_db    <= '0;
            edge_lat <= '0;
            irq_en   <= '0;
            led_reg  <= LED_RST;
            rdata    <= '0;
            irq      <= 1'b0;
            // NOTE: the counter array is real flops, not RAM, so it is reset explicitly;
            // a mid-debounce reset must never leave a partial count behind.
            for (int i = 0; i < N_SW; i++) cnt[i] <= '0;
        end else begin
            sync1    <= switches;
            s        <= sync1;
            sw_db    <= sw_db_next;
            edge_lat <= edge_next;
            for (int i = 0; i < N_SW; i++) cnt[i] <= cnt_next[i];

            if (we && reg_sel_t'(addr) == REG_LED)    led_reg <= wdata[N_LED-1:0];
            if (we && reg_sel_t'(addr) == REG_IRQ_EN) irq_en  <= wdata[N_SW-1:0];

            // Reads see pre-edge state, so a simultaneous write returns the old value.
            if (re) rdata <= rd_val;
            irq <= |(edge_lat & irq_en);
        end
    end

    assign leds = led_reg;

endmodule
